// File: rtl/mesi_pkg.sv
// rtl/mesi_pkg.sv - MESI coherence types and the snoop transition function
package mesi_pkg;

  typedef enum logic [1:0] {
    MESI_M = 2'b00,
    MESI_E = 2'b01,
    MESI_S = 2'b10,
    MESI_I = 2'b11
  } mesi_t;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_RSVD = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoop_res_t;

  typedef logic [1:0] snoop_fsm_t;
  localparam snoop_fsm_t ST_IDLE   = 2'd0;
  localparam snoop_fsm_t ST_LOOKUP = 2'd1;
  localparam snoop_fsm_t ST_FLUSH  = 2'd2;
  localparam snoop_fsm_t ST_RESP   = 2'd3;

  typedef struct packed {
    mesi_t      nxt;
    snoop_res_t res;
    logic       flush;
    logic       err;
  } snoop_out_t;

  // Illegal combinations (upgrade of an owned line, reserved op) leave the line untouched.
  function automatic snoop_out_t snoop_next(mesi_t cur, bus_op_t op);
    snoop_out_t o;
    o.nxt   = cur;
    o.res   = NOHIT;
    o.flush = 1'b0;
    o.err   = 1'b0;
    case (op)
      BUS_RD: begin
        case (cur)
          MESI_M: begin o.nxt = MESI_S; o.res = HITM; o.flush = 1'b1; end
          MESI_E, MESI_S: begin o.nxt = MESI_S; o.res = HIT; end
          default: o.nxt = MESI_I;
        endcase
      end
      BUS_RDX: begin
        o.nxt = MESI_I;
        case (cur)
          MESI_M: begin o.res = HITM; o.flush = 1'b1; end
          MESI_E, MESI_S: o.res = HIT;
          default: o.res = NOHIT;
        endcase
      end
      BUS_UPGR: begin
        case (cur)
          MESI_S: begin o.nxt = MESI_I; o.res = HIT; end
          MESI_I: o.res = NOHIT;
          default: o.err = 1'b1;
        endcase
      end
      default: o.err = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mesi_snoop_responder.sv
// rtl/mesi_snoop_responder.sv - MESI state array owner answering bus snoops
module mesi_snoop_responder
  import mesi_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snoop_valid,
  output logic             snoop_ready,
  input  logic [1:0]       snoop_op,
  input  logic [IDX_W-1:0] snoop_idx,
  output logic             snoop_resp_valid,
  output logic [1:0]       snoop_result,
  output logic             snoop_err,
  output logic             flush_req,
  output logic [IDX_W-1:0] flush_idx,
  input  logic             flush_ack,
  input  logic [IDX_W-1:0] st_rd_idx,
  output logic [1:0]       st_rd_state,
  input  logic             st_wr_en,
  input  logic [IDX_W-1:0] st_wr_idx,
  input  logic [1:0]       st_wr_state,
  output logic             st_wr_nack,
  output logic [CNT_W-1:0] snoop_cnt,
  output logic [CNT_W-1:0] hitm_cnt
);

  snoop_fsm_t       state_q, state_d;
  bus_op_t          op_q;
  logic [IDX_W-1:0] idx_q;
  mesi_t            lines_q [NUM_LINES];
  snoop_out_t       pend_q;
  snoop_res_t       result_q;
  logic             err_q;
  logic             nack_q;

  snoop_out_t lk;
  snoop_out_t wr_val;
  logic       accept;
  logic       snoop_wr_en;
  logic       cpu_wr_ok;

  always_comb begin
    lk          = snoop_next(lines_q[idx_q], op_q);
    accept      = (state_q == ST_IDLE) && snoop_valid;
    snoop_wr_en = ((state_q == ST_LOOKUP) && !lk.flush) ||
                  ((state_q == ST_FLUSH) && flush_ack);
    wr_val      = (state_q == ST_FLUSH) ? pend_q : lk;
    // A busy snoop owns its line until the transition has been written.
    cpu_wr_ok   = st_wr_en && ((state_q == ST_IDLE) || (st_wr_idx != idx_q));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (snoop_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = lk.flush ? ST_FLUSH : ST_RESP;
      ST_FLUSH:  if (flush_ack) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= BUS_RD;
      idx_q    <= '0;
      pend_q   <= '0;
      result_q <= NOHIT;
      err_q    <= 1'b0;
      nack_q   <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        lines_q[i] <= MESI_I;
      end
    end else begin
      state_q <= state_d;
      nack_q  <= st_wr_en && !cpu_wr_ok;
      if (accept) begin
        op_q  <= bus_op_t'(snoop_op);
        idx_q <= snoop_idx;
      end
      if (state_q == ST_LOOKUP) begin
        pend_q <= lk;
      end
      if (snoop_wr_en) begin
        lines_q[idx_q] <= wr_val.nxt;
        result_q       <= wr_val.res;
        err_q          <= wr_val.err;
      end
      // Applied after the snoop write so that the IDLE-accept case lands before LOOKUP.
      if (cpu_wr_ok) begin
        lines_q[st_wr_idx] <= mesi_t'(st_wr_state);
      end
    end
  end

  assign snoop_ready      = (state_q == ST_IDLE);
  assign snoop_resp_valid = (state_q == ST_RESP);
  assign snoop_result     = result_q;
  assign snoop_err        = err_q;
  assign flush_req        = (state_q == ST_FLUSH);
  assign flush_idx        = idx_q;
  assign st_rd_state      = lines_q[st_rd_idx];
  assign st_wr_nack       = nack_q;

  sat_counter #(.CNT_W(CNT_W)) u_snoop_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .inc_i   (accept),
    .count_o (snoop_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hitm_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .inc_i   ((state_q == ST_RESP) && (result_q == HITM)),
    .count_o (hitm_cnt)
  );

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// tb/tb_mesi_snoop_responder.sv - scoreboard bench for mesi_snoop_responder
module tb_mesi_snoop_responder;

  localparam int IDX_W = 4;
  localparam int CNT_W = 16;

  localparam logic [1:0] ST_M = 2'b00, ST_E = 2'b01, ST_S = 2'b10, ST_I = 2'b11;
  localparam logic [1:0] OP_RD = 2'd0, OP_RDX = 2'd1, OP_UPGR = 2'd2, OP_RSVD = 2'd3;
  localparam int R_NOHIT = 0, R_HIT = 1, R_HITM = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             snoop_valid = 1'b0;
  logic             snoop_ready;
  logic [1:0]       snoop_op = 2'd0;
  logic [IDX_W-1:0] snoop_idx = '0;
  logic             snoop_resp_valid;
  logic [1:0]       snoop_result;
  logic             snoop_err;
  logic             flush_req;
  logic [IDX_W-1:0] flush_idx;
  logic             flush_ack = 1'b0;
  logic [IDX_W-1:0] st_rd_idx = '0;
  logic [1:0]       st_rd_state;
  logic             st_wr_en = 1'b0;
  logic [IDX_W-1:0] st_wr_idx = '0;
  logic [1:0]       st_wr_state = 2'd0;
  logic             st_wr_nack;
  logic [CNT_W-1:0] snoop_cnt;
  logic [CNT_W-1:0] hitm_cnt;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q [$];

  mesi_snoop_responder #(.NUM_LINES(16), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .snoop_valid      (snoop_valid),
    .snoop_ready      (snoop_ready),
    .snoop_op         (snoop_op),
    .snoop_idx        (snoop_idx),
    .snoop_resp_valid (snoop_resp_valid),
    .snoop_result     (snoop_result),
    .snoop_err        (snoop_err),
    .flush_req        (flush_req),
    .flush_idx        (flush_idx),
    .flush_ack        (flush_ack),
    .st_rd_idx        (st_rd_idx),
    .st_rd_state      (st_rd_state),
    .st_wr_en         (st_wr_en),
    .st_wr_idx        (st_wr_idx),
    .st_wr_state      (st_wr_state),
    .st_wr_nack       (st_wr_nack),
    .snoop_cnt        (snoop_cnt),
    .hitm_cnt         (hitm_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT strobes a result.
  always @(negedge clk) begin
    if (!rst && snoop_resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got result %0d err %0d, expected no response",
                 snoop_result, snoop_err);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if ({snoop_result, snoop_err} != e) begin
          errors++;
          $display("FAIL resp: got result %0d err %0d, expected result %0d err %0d",
                   snoop_result, snoop_err, e[2:1], e[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [1:0] st);
    st_wr_en    = 1'b1;
    st_wr_idx   = 4'(idx);
    st_wr_state = st;
    step();
    st_wr_en    = 1'b0;
  endtask

  task automatic chk_line(input int idx, input logic [1:0] st);
    st_rd_idx = 4'(idx);
    step();
    chk($sformatf("line%0d", idx), int'(st_rd_state), int'(st));
  endtask

  task automatic snoop(input logic [1:0] op, input int idx, input int exp_res,
                       input int exp_err, input int ack_dly, input int exp_lat,
                       input int exp_fl);
    int lat;
    int fcnt;
    bit done;
    chk("ready_before", int'(snoop_ready), 1);
    exp_q.push_back({2'(exp_res), 1'(exp_err)});
    snoop_valid = 1'b1;
    snoop_op    = op;
    snoop_idx   = 4'(idx);
    step();
    snoop_valid = 1'b0;
    st_wr_en    = 1'b0;
    lat  = 0;
    fcnt = 0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      step();
      lat++;
      if (snoop_resp_valid) begin
        done = 1'b1;
      end else if (flush_req) begin
        fcnt++;
        chk("flush_idx", int'(flush_idx), idx);
        flush_ack = (fcnt > ack_dly);
      end
    end
    flush_ack = 1'b0;
    if (!done) chk("resp_timeout", 0, 1);
    chk("resp_latency", lat + 1, exp_lat);
    chk("flush_cycles", fcnt, exp_fl);
    step();
    chk("resp_one_cycle", int'(snoop_resp_valid), 0);
    chk("ready_after", int'(snoop_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", int'(snoop_ready), 1);
    chk("rst_resp_valid", int'(snoop_resp_valid), 0);
    chk("rst_result", int'(snoop_result), R_NOHIT);
    chk("rst_err", int'(snoop_err), 0);
    chk("rst_flush_req", int'(flush_req), 0);
    chk("rst_flush_idx", int'(flush_idx), 0);
    chk("rst_nack", int'(st_wr_nack), 0);
    chk("rst_snoop_cnt", int'(snoop_cnt), 0);
    chk("rst_hitm_cnt", int'(hitm_cnt), 0);

    snoop(OP_RD, 3, R_NOHIT, 0, 0, 2, 0);
    chk_line(3, ST_I);
    chk("snoop_cnt_1", int'(snoop_cnt), 1);

    wr(5, ST_E);
    snoop(OP_RD, 5, R_HIT, 0, 0, 2, 0);
    chk_line(5, ST_S);

    wr(7, ST_M);
    snoop(OP_RDX, 7, R_HITM, 0, 3, 6, 4);
    chk_line(7, ST_I);
    chk("hitm_cnt_1", int'(hitm_cnt), 1);

    wr(2, ST_M);
    snoop(OP_UPGR, 2, R_NOHIT, 1, 0, 2, 0);
    chk_line(2, ST_M);

    wr(11, ST_M);
    snoop(OP_RD, 11, R_HITM, 0, 0, 3, 1);
    chk_line(11, ST_S);
    chk("hitm_cnt_2", int'(hitm_cnt), 2);

    snoop(OP_RSVD, 11, R_NOHIT, 1, 0, 2, 0);
    chk_line(11, ST_S);
    snoop(OP_UPGR, 11, R_HIT, 0, 0, 2, 0);
    chk_line(11, ST_I);

    // Write and snoop accept on the same line in the same IDLE cycle.
    st_wr_en    = 1'b1;
    st_wr_idx   = 4'd6;
    st_wr_state = ST_S;
    snoop(OP_RDX, 6, R_HIT, 0, 0, 2, 0);
    chk_line(6, ST_I);
    chk("snoop_cnt_8", int'(snoop_cnt), 8);

    // CPU writes during a flush of line 9.
    wr(9, ST_M);
    wr(4, ST_E);
    exp_q.push_back({2'(R_HITM), 1'b0});
    snoop_valid = 1'b1;
    snoop_op    = OP_RD;
    snoop_idx   = 4'd9;
    step();
    snoop_valid = 1'b0;
    step();
    chk("nack_flush_req", int'(flush_req), 1);
    st_wr_en    = 1'b1;
    st_wr_idx   = 4'd9;
    st_wr_state = ST_E;
    step();
    chk("nack_pulse", int'(st_wr_nack), 1);
    st_wr_idx   = 4'd4;
    st_wr_state = ST_S;
    step();
    chk("nack_clear", int'(st_wr_nack), 0);
    st_wr_en  = 1'b0;
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    chk("nack_resp", int'(snoop_resp_valid), 1);
    step();
    chk("nack_flush_drop", int'(flush_req), 0);
    chk_line(9, ST_S);
    chk_line(4, ST_S);
    chk("hitm_cnt_3", int'(hitm_cnt), 3);
    chk("snoop_cnt_9", int'(snoop_cnt), 9);

    // Reset while flushing aborts the snoop.
    wr(9, ST_M);
    wr(1, ST_E);
    snoop_valid = 1'b1;
    snoop_op    = OP_RDX;
    snoop_idx   = 4'd9;
    step();
    snoop_valid = 1'b0;
    step();
    chk("abort_flush_req", int'(flush_req), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_flush_drop", int'(flush_req), 0);
    chk("abort_no_resp", int'(snoop_resp_valid), 0);
    chk("abort_snoop_cnt", int'(snoop_cnt), 0);
    chk("abort_hitm_cnt", int'(hitm_cnt), 0);
    for (int i = 0; i < 16; i++) begin
      chk_line(i, ST_I);
    end
    chk("abort_still_no_resp", int'(snoop_resp_valid), 0);

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
